rv32m_iter_divider: RTL

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It consumes Op1/Op2 from the ALU input selector and delivers its result to the ALU select mux in place of the combinational divide path. While a divide is in flight it drives a stall that holds the program counter (CPU_PCWrite = ~div_stall). Multiply remains combinational in the M-ALU.

---
 rtl/rv32m_iter_divider_pkg.sv | 33 +++
 rtl/rv32m_iter_divider_div_step.sv | 25 ++
 rtl/rv32m_iter_divider.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rv32m_iter_divider_pkg.sv
// Shared encodings for the RV32M iterative divider: funct3[1:0] op codes,
// FSM state encodings and the per-operation context latched at start.
package rv32m_iter_divider_pkg;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Everything needed at the end of the iteration to pick and sign-fix the result.
    typedef struct packed {
        logic is_rem;
        logic q_neg;
        logic r_neg;
    } div_ctx_t;

    function automatic logic div_op_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic div_op_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/rv32m_iter_divider_div_step.sv
// One restoring radix-2 division step on magnitudes: shift {rem,quo} left,
// subtract the divisor when it fits and shift the outcome into the quotient.
module rv32m_iter_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    // One extra guard bit so the borrow of the trial subtraction is explicit.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign diff    = shifted - {2'b00, divisor};
    assign fits    = ~diff[WIDTH+1];

    assign rem_out = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
    assign quo_out = {quo_in[WIDTH-2:0], fits};

endmodule

// File: rtl/rv32m_iter_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: one restoring step per cycle,
// special cases resolved in one cycle, stalls the PC while a divide is pending.
module rv32m_iter_divider
    import rv32m_iter_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CPU_clk,
    input  logic             CPU_rst_n,
    input  logic             div_start,
    input  logic [1:0]       div_op,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    output logic [WIDTH-1:0] div_result,
    output logic             div_done,
    output logic             div_busy,
    output logic             div_stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state, state_nxt;
    logic [WIDTH:0]   rem_q, rem_nxt;
    logic [WIDTH-1:0] quo_q, quo_nxt;
    logic [WIDTH-1:0] dvsr_q;
    logic [CNT_W-1:0] cnt_q;
    div_ctx_t         ctx_q, ctx_in;

    logic             op_signed, op_rem;
    logic             dvsr_zero, sgn_ovf, special;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH-1:0] op1_mag, op2_mag;
    logic             last_step;
    logic [WIDTH-1:0] quo_mag, rem_mag, final_res;
    logic             start_run, start_special, step_en;

    assign op_signed = div_op_signed(div_op);
    assign op_rem    = div_op_rem(div_op);

    // Architecturally defined results that bypass the iteration entirely.
    assign dvsr_zero = (Op2 == '0);
    assign sgn_ovf   = op_signed && (Op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (Op2 == '1);
    assign special   = dvsr_zero | sgn_ovf;

    always_comb begin
        special_res = '0;
        if (dvsr_zero)
            special_res = op_rem ? Op1 : '1;
        else
            special_res = op_rem ? '0 : Op1;
    end

    assign op1_mag = (op_signed && Op1[WIDTH-1]) ? -Op1 : Op1;
    assign op2_mag = (op_signed && Op2[WIDTH-1]) ? -Op2 : Op2;

    assign ctx_in.is_rem = op_rem;
    assign ctx_in.q_neg  = op_signed & (Op1[WIDTH-1] ^ Op2[WIDTH-1]);
    assign ctx_in.r_neg  = op_signed & Op1[WIDTH-1];

    rv32m_iter_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvsr_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    assign last_step = (cnt_q == CNT_W'(1));
    assign quo_mag   = ctx_q.q_neg ? -quo_nxt : quo_nxt;
    assign rem_mag   = ctx_q.r_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
    assign final_res = ctx_q.is_rem ? rem_mag : quo_mag;

    assign start_run     = (state == DIV_IDLE) && div_start && !special;
    assign start_special = (state == DIV_IDLE) && div_start && special;
    assign step_en       = (state == DIV_RUN) && div_start;

    // State register
    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n)
            state <= DIV_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: begin
                if (div_start)
                    state_nxt = special ? DIV_DONE : DIV_RUN;
            end
            DIV_RUN: begin
                if (!div_start)
                    state_nxt = DIV_IDLE;
                else if (last_step)
                    state_nxt = DIV_DONE;
            end
            DIV_DONE: state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        div_busy = 1'b0;
        div_done = 1'b0;
        case (state)
            DIV_RUN:  div_busy = 1'b1;
            DIV_DONE: div_done = 1'b1;
            default: ;
        endcase
    end

    assign div_stall = div_start & ~div_done & CPU_rst_n;

    // Iteration datapath; an abort simply leaves everything untouched.
    always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            cnt_q      <= '0;
            ctx_q      <= '0;
            div_result <= '0;
        end else begin
            if (start_run) begin
                rem_q  <= '0;
                quo_q  <= op1_mag;
                dvsr_q <= op2_mag;
                cnt_q  <= CNT_W'(WIDTH);
                ctx_q  <= ctx_in;
            end else if (step_en) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (start_special)
                div_result <= special_res;
            else if (step_en && last_step)
                div_result <= final_res;
        end
    end

endmodule
